// File: rtl/sram_responder.sv
// sram_responder
// Cycle-accurate stand-in for the 16-bit external SRAM chip behind the memory
// stage's SRAM pins. It decodes the active-low strobes on every rising edge,
// commits writes into an internal word array, and returns read data on the
// bidirectional bus after READ_LAT edges.
//
// READ_LAT counts edges starting with the edge that first samples the read
// request. With READ_LAT=1 that edge captures the word and the bus is driven
// straight after it. With READ_LAT=N the responder spends N-1 cycles in WAIT
// (busy high) and the word is driven after the N-th edge.
//
// Build option:
//   SRAM_BYTE_MASK_EN  when defined, writes update only the byte lanes whose
//                      UB_N/LB_N strobe is low. When undefined, the lane
//                      strobes are ignored and every write stores the full
//                      word.
//
// The storage array has no reset. A reset only clears the read FSM and the
// activity counters. The all-zero power-up content comes from the
// zero-initialised storage of the target: FPGA block-RAM configuration or a
// two-state simulator.
module sram_responder #(
  parameter int DEPTH_LOG2 = 16,
  parameter int READ_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [15:0] SRAM_DQ,
  input  logic [17:0] SRAM_ADDR,
  input  logic        SRAM_UB_N,
  input  logic        SRAM_LB_N,
  input  logic        SRAM_WE_N,
  input  logic        SRAM_CE_N,
  input  logic        SRAM_OE_N,
  output logic        busy,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_LOAD = 4'(READ_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRIVE
  } state_t;

  state_t                r_state;
  state_t                w_stateNext;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cntNext;
  logic [3:0]            w_cntDec;
  logic [DEPTH_LOG2-1:0] r_addr;
  logic [DEPTH_LOG2-1:0] w_addrNext;
  logic [DEPTH_LOG2-1:0] w_addrEff;
  logic [DEPTH_LOG2-1:0] w_capAddr;
  logic [15:0]           r_data;
  logic [15:0]           r_mem [0:DEPTH-1];
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_addrHit;
  logic                  w_launch;
  logic                  w_capture;
  logic                  w_drive;

  // Upper address bits beyond the array depth are ignored, so addresses alias.
  assign w_addrEff = SRAM_ADDR[DEPTH_LOG2-1:0];

  // The address pins above the array depth take no part in decoding.
  generate
    if (DEPTH_LOG2 < 18) begin : g_addrAlias
      logic w_unusedAddrHigh;
      assign w_unusedAddrHigh = ^SRAM_ADDR[17:DEPTH_LOG2];
    end
  endgenerate

  // Request decode. A low WE_N always means a write, whatever OE_N is doing.
  // This makes WR and RD mutually exclusive.
  assign w_wr = !SRAM_CE_N && !SRAM_WE_N;
  assign w_rd = !SRAM_CE_N &&  SRAM_WE_N && !SRAM_OE_N;

  assign w_addrHit = (w_addrEff == r_addr);
  assign w_cntDec  = r_cnt - 4'd1;

  // The bus is gated straight from the pins. It lets go in the same cycle that
  // the controller drops OE_N or CE_N, or pulls WE_N low to start a write.
  assign w_drive = (r_state == S_DRIVE) && w_rd;
  assign SRAM_DQ = w_drive ? r_data : 16'hzzzz;

  assign busy = (r_state == S_WAIT);

  // Next-state decode for the read FSM.
  // Launching a read happens in three cases: a fresh request from IDLE, or a
  // change of address while in WAIT or DRIVE. Every launch restarts the
  // latency count from the beginning.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_addrNext  = r_addr;
    w_capAddr   = r_addr;
    w_capture   = 1'b0;
    w_launch    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_rd) begin
          w_launch = 1'b1;
        end
      end
      S_WAIT: begin
        if (!w_rd) begin
          w_stateNext = S_IDLE;
        end else if (!w_addrHit) begin
          w_launch = 1'b1;
        end else if (w_cntDec == 4'd0) begin
          w_capture   = 1'b1;
          w_cntNext   = 4'd0;
          w_stateNext = S_DRIVE;
        end else begin
          w_cntNext = w_cntDec;
        end
      end
      S_DRIVE: begin
        if (!w_rd) begin
          w_stateNext = S_IDLE;
        end else if (!w_addrHit) begin
          w_launch = 1'b1;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase

    if (w_launch) begin
      w_addrNext = w_addrEff;
      w_capAddr  = w_addrEff;
      if (READ_LAT == 1) begin
        w_capture   = 1'b1;
        w_cntNext   = 4'd0;
        w_stateNext = S_DRIVE;
      end else begin
        w_cntNext   = LAT_LOAD;
        w_stateNext = S_WAIT;
      end
    end
  end

  // FSM registers, the captured read word and the activity counters.
  // A word is captured exactly when a read reaches DRIVE, so that is also the
  // edge where rd_count advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_addr   <= '0;
      r_data   <= 16'h0000;
      rd_count <= 16'h0000;
      wr_count <= 16'h0000;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_addr  <= w_addrNext;
      if (w_capture) begin
        r_data   <= r_mem[w_capAddr];
        rd_count <= rd_count + 16'd1;
      end
      if (w_wr) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

`ifndef SRAM_BYTE_MASK_EN
  // The lane strobes only matter when byte masking is built in.
  logic w_unusedLanes;
  assign w_unusedLanes = SRAM_UB_N ^ SRAM_LB_N;
`endif

  // Storage writes. Every edge that samples WR commits one write. Reset
  // blocks a write on the same edge but never clears the stored contents.
  always_ff @(posedge clk) begin
    if (!rst && w_wr) begin
`ifdef SRAM_BYTE_MASK_EN
      if (!SRAM_LB_N) begin
        r_mem[w_addrEff][7:0] <= SRAM_DQ[7:0];
      end
      if (!SRAM_UB_N) begin
        r_mem[w_addrEff][15:8] <= SRAM_DQ[15:8];
      end
`else
      r_mem[w_addrEff] <= SRAM_DQ;
`endif
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder
// Drives three sram_responder instances from one shared set of strobes:
//   instance 0: DEPTH_LOG2=16, READ_LAT=2
//   instance 1: DEPTH_LOG2=4,  READ_LAT=3
//   instance 2: DEPTH_LOG2=4,  READ_LAT=1
// Each instance has its own data bus. A run-length read model predicts busy,
// the driven word and both counters on every cycle. Directed literal checks
// pin the model against hand-worked scenarios.
module tb_sram_responder;

  localparam int LAT [3] = '{2, 3, 1};
  localparam int DEP [3] = '{16, 4, 4};

  logic        clk;
  logic        rst;
  logic        ceN;
  logic        weN;
  logic        oeN;
  logic        ubN;
  logic        lbN;
  logic [17:0] addrPin;
  logic        tbDrive;
  logic [15:0] tbData;

  wire  [15:0] dq0;
  wire  [15:0] dq1;
  wire  [15:0] dq2;
  wire         busy0;
  wire         busy1;
  wire         busy2;
  wire  [15:0] rdc0;
  wire  [15:0] rdc1;
  wire  [15:0] rdc2;
  wire  [15:0] wrc0;
  wire  [15:0] wrc1;
  wire  [15:0] wrc2;

  int checks;
  int passes;

  // Read model state: a run length of identical read edges per instance.
  logic [15:0] mMem [3][65536];
  int          mLen  [3];
  int          mAddr [3];
  logic [15:0] mCap  [3];
  logic [15:0] mRd   [3];
  logic [15:0] mWr   [3];
  logic        modelReady;
  logic [15:0] rdBefore;

  assign dq0 = tbDrive ? tbData : 16'hzzzz;
  assign dq1 = tbDrive ? tbData : 16'hzzzz;
  assign dq2 = tbDrive ? tbData : 16'hzzzz;

  sram_responder #(.DEPTH_LOG2(16), .READ_LAT(2)) u_dut0 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq0), .SRAM_ADDR(addrPin),
    .SRAM_UB_N(ubN), .SRAM_LB_N(lbN), .SRAM_WE_N(weN), .SRAM_CE_N(ceN),
    .SRAM_OE_N(oeN), .busy(busy0), .rd_count(rdc0), .wr_count(wrc0)
  );

  sram_responder #(.DEPTH_LOG2(4), .READ_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq1), .SRAM_ADDR(addrPin),
    .SRAM_UB_N(ubN), .SRAM_LB_N(lbN), .SRAM_WE_N(weN), .SRAM_CE_N(ceN),
    .SRAM_OE_N(oeN), .busy(busy1), .rd_count(rdc1), .wr_count(wrc1)
  );

  sram_responder #(.DEPTH_LOG2(4), .READ_LAT(1)) u_dut2 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq2), .SRAM_ADDR(addrPin),
    .SRAM_UB_N(ubN), .SRAM_LB_N(lbN), .SRAM_WE_N(weN), .SRAM_CE_N(ceN),
    .SRAM_OE_N(oeN), .busy(busy2), .rd_count(rdc2), .wr_count(wrc2)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      passes++;
    end
  endtask

  // A released bus reads as Z, or as zero on a two-state simulator.
  function automatic logic busReleased(input logic [15:0] v);
    return (v === 16'hzzzz) || (v == 16'h0000);
  endfunction

  function automatic logic [15:0] dqOf(input int i);
    case (i)
      0:       return dq0;
      1:       return dq1;
      default: return dq2;
    endcase
  endfunction

  function automatic logic busyOf(input int i);
    case (i)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic [15:0] rdcOf(input int i);
    case (i)
      0:       return rdc0;
      1:       return rdc1;
      default: return rdc2;
    endcase
  endfunction

  function automatic logic [15:0] wrcOf(input int i);
    case (i)
      0:       return wrc0;
      1:       return wrc1;
      default: return wrc2;
    endcase
  endfunction

  // One edge of the model for instance i.
  // A read has reached its data once the same address has been requested on
  // LAT consecutive edges. The word is captured on the edge where that first
  // happens.
  task automatic modelStep(input int i);
    int   ea;
    logic isWr;
    logic isRd;
    logic reached;
    ea      = int'(addrPin) & ((1 << DEP[i]) - 1);
    isWr    = !ceN && !weN;
    isRd    = !ceN && weN && !oeN;
    reached = 1'b0;
    if (rst) begin
      mLen[i] = 0;
      mRd[i]  = 16'h0000;
      mWr[i]  = 16'h0000;
      mCap[i] = 16'h0000;
    end else if (isWr) begin
`ifdef SRAM_BYTE_MASK_EN
      if (!lbN) mMem[i][ea][7:0]  = tbData[7:0];
      if (!ubN) mMem[i][ea][15:8] = tbData[15:8];
`else
      mMem[i][ea] = tbData;
`endif
      mWr[i]  = mWr[i] + 16'd1;
      mLen[i] = 0;
    end else if (isRd) begin
      if (mLen[i] == 0 || ea != mAddr[i]) begin
        mLen[i]  = 1;
        mAddr[i] = ea;
        reached  = (LAT[i] == 1);
      end else if (mLen[i] < LAT[i]) begin
        mLen[i] = mLen[i] + 1;
        reached = (mLen[i] == LAT[i]);
      end
      if (reached) begin
        mCap[i] = mMem[i][ea];
        mRd[i]  = mRd[i] + 16'd1;
      end
    end else begin
      mLen[i] = 0;
    end
  endtask

  // Advance the model on every rising edge, using the pins as they stood
  // at that edge.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) modelStep(i);
    modelReady = 1'b1;
  end

  // Check every instance against the model shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (modelReady) begin
      for (int i = 0; i < 3; i++) begin
        logic expBusy;
        logic expDrive;
        expBusy  = (mLen[i] >= 1) && (mLen[i] < LAT[i]);
        expDrive = (mLen[i] >= LAT[i]) && !ceN && weN && !oeN;
        checkOutput($sformatf("model_busy%0d", i), {15'd0, busyOf(i)}, {15'd0, expBusy});
        checkOutput($sformatf("model_rdcount%0d", i), rdcOf(i), mRd[i]);
        checkOutput($sformatf("model_wrcount%0d", i), wrcOf(i), mWr[i]);
        if (expDrive) begin
          checkOutput($sformatf("model_dq%0d", i), dqOf(i), mCap[i]);
        end else if (!tbDrive) begin
          checkOutput($sformatf("model_release%0d", i), {15'd0, busReleased(dqOf(i))}, 16'd1);
        end
      end
    end
  end

  task automatic applyStimulus(input logic aCe, input logic aWe, input logic aOe,
                               input logic aUb, input logic aLb, input logic [17:0] aAddr,
                               input logic aDrv, input logic [15:0] aData);
    @(negedge clk);
    ceN     = aCe;
    weN     = aWe;
    oeN     = aOe;
    ubN     = aUb;
    lbN     = aLb;
    addrPin = aAddr;
    tbDrive = aDrv;
    tbData  = aData;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 1'b0, 16'h0000);
  endtask

  task automatic writeWord(input logic [17:0] a, input logic [15:0] d, input logic u, input logic l);
    applyStimulus(1'b0, 1'b0, 1'b1, u, l, a, 1'b1, d);
  endtask

  task automatic readCycle(input logic [17:0] a);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a, 1'b0, 16'h0000);
  endtask

  task automatic sampleAfterEdge();
    @(posedge clk);
    #2;
  endtask

  // Directed scenarios with hand-worked expectations.
  initial begin
    checks     = 0;
    passes     = 0;
    modelReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mLen[i]  = 0;
      mAddr[i] = 0;
      mCap[i]  = 16'h0000;
      mRd[i]   = 16'h0000;
      mWr[i]   = 16'h0000;
      for (int j = 0; j < 65536; j++) mMem[i][j] = 16'h0000;
    end
    rst     = 1'b1;
    ceN     = 1'b1;
    weN     = 1'b1;
    oeN     = 1'b1;
    ubN     = 1'b1;
    lbN     = 1'b1;
    addrPin = 18'h0;
    tbDrive = 1'b0;
    tbData  = 16'h0000;

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_busy", {15'd0, busy0}, 16'd0);
    checkOutput("reset_rdcount", rdc0, 16'd0);
    checkOutput("reset_wrcount", wrc0, 16'd0);
    checkOutput("reset_release", {15'd0, busReleased(dq0)}, 16'd1);
    @(negedge clk);
    rst = 1'b0;

    // Basic write then read at READ_LAT=2, plus the READ_LAT=1 instance.
    writeWord(18'h00010, 16'h1234, 1'b0, 1'b0);
    idleCycle();
    readCycle(18'h00010);
    sampleAfterEdge();
    checkOutput("basic_busy_wait", {15'd0, busy0}, 16'd1);
    checkOutput("lat1_never_busy", {15'd0, busy2}, 16'd0);
    checkOutput("lat1_dq", dq2, 16'h1234);
    readCycle(18'h00010);
    sampleAfterEdge();
    checkOutput("basic_dq", dq0, 16'h1234);
    checkOutput("basic_busy_done", {15'd0, busy0}, 16'd0);
    checkOutput("basic_rdcount", rdc0, 16'd1);
    checkOutput("basic_wrcount", wrc0, 16'd1);
    readCycle(18'h00010);

    // Read aborted by a write in DRIVE: OE_N rises, then WE_N falls, same cycle.
    @(negedge clk);
    oeN = 1'b1;
    #1;
    checkOutput("abort_release", {15'd0, busReleased(dq0)}, 16'd1);
    #1;
    weN     = 1'b0;
    tbDrive = 1'b1;
    tbData  = 16'h5A5A;
    sampleAfterEdge();
    checkOutput("abort_idle", {15'd0, busy0}, 16'd0);
    idleCycle();
    readCycle(18'h00010);
    readCycle(18'h00010);
    sampleAfterEdge();
    checkOutput("abort_mem", dq0, 16'h5A5A);
    idleCycle();

    // Byte-lane write: upper lane only.
    writeWord(18'h00005, 16'hFFFF, 1'b0, 1'b0);
    writeWord(18'h00005, 16'hAB00, 1'b0, 1'b1);
    idleCycle();
    readCycle(18'h00005);
    readCycle(18'h00005);
    sampleAfterEdge();
`ifdef SRAM_BYTE_MASK_EN
    checkOutput("bytemask_dq", dq0, 16'hABFF);
`else
    checkOutput("bytemask_dq", dq0, 16'hAB00);
`endif
    idleCycle();

    // Aliasing: 0x10005 and 0x00005 are the same word at DEPTH_LOG2=16.
    writeWord(18'h10005, 16'h0F0F, 1'b0, 1'b0);
    idleCycle();
    readCycle(18'h00005);
    readCycle(18'h00005);
    sampleAfterEdge();
    checkOutput("alias_dq", dq0, 16'h0F0F);
    idleCycle();

    // Address change mid-WAIT on the READ_LAT=3 instance.
    writeWord(18'h00001, 16'h1111, 1'b0, 1'b0);
    writeWord(18'h00002, 16'h2222, 1'b0, 1'b0);
    idleCycle();
    rdBefore = mRd[1];
    readCycle(18'h00001);
    sampleAfterEdge();
    checkOutput("midwait_busy_a", {15'd0, busy1}, 16'd1);
    readCycle(18'h00002);
    sampleAfterEdge();
    checkOutput("midwait_busy_b", {15'd0, busy1}, 16'd1);
    readCycle(18'h00002);
    sampleAfterEdge();
    checkOutput("midwait_busy_c", {15'd0, busy1}, 16'd1);
    readCycle(18'h00002);
    sampleAfterEdge();
    checkOutput("midwait_busy_end", {15'd0, busy1}, 16'd0);
    checkOutput("midwait_dq", dq1, 16'h2222);
    checkOutput("midwait_rdcount", rdc1, rdBefore + 16'd1);
    idleCycle();

    // Reset asserted during WAIT; memory must survive it.
    readCycle(18'h00010);
    sampleAfterEdge();
    checkOutput("rstread_busy_before", {15'd0, busy0}, 16'd1);
    @(negedge clk);
    rst = 1'b1;
    sampleAfterEdge();
    checkOutput("rstread_busy", {15'd0, busy0}, 16'd0);
    checkOutput("rstread_rdcount", rdc0, 16'd0);
    checkOutput("rstread_wrcount", wrc0, 16'd0);
    checkOutput("rstread_release", {15'd0, busReleased(dq0)}, 16'd1);
    @(negedge clk);
    rst = 1'b0;
    readCycle(18'h00010);
    sampleAfterEdge();
    checkOutput("rstread_mem_kept", dq0, 16'h5A5A);
    idleCycle();

    // Reset wins over a simultaneous write.
    writeWord(18'h00020, 16'h3333, 1'b0, 1'b0);
    idleCycle();
    @(negedge clk);
    rst     = 1'b1;
    ceN     = 1'b0;
    weN     = 1'b0;
    oeN     = 1'b1;
    ubN     = 1'b0;
    lbN     = 1'b0;
    addrPin = 18'h00020;
    tbDrive = 1'b1;
    tbData  = 16'h7777;
    sampleAfterEdge();
    checkOutput("rstwr_wrcount", wrc0, 16'd0);
    @(negedge clk);
    rst     = 1'b0;
    ceN     = 1'b1;
    weN     = 1'b1;
    tbDrive = 1'b0;
    readCycle(18'h00020);
    readCycle(18'h00020);
    sampleAfterEdge();
    checkOutput("rstwr_blocked", dq0, 16'h3333);
    idleCycle();

    // WE_N held low for three edges commits three times.
    writeWord(18'h00030, 16'hC0DE, 1'b0, 1'b0);
    writeWord(18'h00030, 16'hC0DE, 1'b0, 1'b0);
    writeWord(18'h00030, 16'hC0DE, 1'b0, 1'b0);
    idleCycle();
    sampleAfterEdge();
    checkOutput("burst_wrcount", wrc0, 16'd3);

    // Write with both lanes disabled still counts.
    writeWord(18'h00030, 16'hBEEF, 1'b1, 1'b1);
    idleCycle();
    sampleAfterEdge();
    checkOutput("nolane_wrcount", wrc0, 16'd4);
    readCycle(18'h00030);
    readCycle(18'h00030);
    sampleAfterEdge();
`ifdef SRAM_BYTE_MASK_EN
    checkOutput("nolane_dq", dq0, 16'hC0DE);
`else
    checkOutput("nolane_dq", dq0, 16'hBEEF);
`endif
    idleCycle();

    // Never-written word reads back as zero.
    readCycle(18'h00040);
    readCycle(18'h00040);
    sampleAfterEdge();
    checkOutput("powerup_zero", dq0, 16'h0000);
    idleCycle();
    repeat (3) idleCycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
